// File: rtl/pong_pkg.sv
// pong_pkg: state and winner encodings shared by the pong control blocks,
// plus small arithmetic helpers.
package pong_pkg;
  typedef enum logic [1:0] {
    NEW_GAME = 2'd0,
    PLAY     = 2'd1,
    NEW_BALL = 2'd2,
    OVER     = 2'd3
  } state_e;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction
  // Frames per motion step: max(base - sec1, 1) at 5 bits, clamped rather than wrapped
  function automatic logic [3:0] calc_div(input logic [4:0] base, input logic [3:0] sec1);
    logic [4:0] d;
    d = base - {1'b0, sec1};
    return ({1'b0, sec1} >= base) ? 4'd1 : d[3:0];
  endfunction
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: divides frame ticks into one-cycle motion-step pulses.
module move_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic [3:0] div,
  output logic       move_en
);
  logic [3:0] cnt_q, cnt_d;
  logic       move_d;
  always_comb begin
    cnt_d  = cnt_q;
    move_d = 1'b0;
    if (clr) cnt_d = '0;
    else if (frame_tick) begin
      // >= so a shrinking divider fires on the next tick instead of wrapping
      move_d = cnt_q >= div - 4'd1;
      cnt_d  = move_d ? '0 : cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      cnt_q   <= '0;
      move_en <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      move_en <= move_d;
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: pong game sequencing -- new game, serve hold, play, scoring
// and game-over, with all outputs registered.
module game_flow_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int BASE_DIV     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       miss1,
  input  logic       miss2,
  input  logic [3:0] sec1,
  output logic [1:0] state,
  output logic       ball_reset,
  output logic       move_en,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner
);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [4:0] BASE       = 5'(BASE_DIV);
  state_e     st_q, st_d;
  logic       start_q, br_q, br_d, dir_q, dir_d, press, p1, p2;
  logic [7:0] srv_q, srv_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] win_q, win_d;
  assign press = start & ~start_q;
  always_comb begin
    st_d  = st_q;
    srv_d = '0;
    s1_d  = s1_q;
    s2_d  = s2_q;
    dir_d = dir_q;
    win_d = win_q;
    p1    = 1'b0;
    p2    = 1'b0;
    case (st_q)
      NEW_GAME: begin
        s1_d  = '0;
        s2_d  = '0;
        win_d = WIN_NONE;
        if (press) begin
          st_d  = NEW_BALL;
          dir_d = 1'b1;
        end
      end
      NEW_BALL: begin
        st_d  = (frame_tick && srv_q == SERVE_LAST) ? PLAY : NEW_BALL;
        srv_d = !frame_tick ? srv_q : (srv_q == SERVE_LAST) ? '0 : srv_q + 8'd1;
      end
      PLAY: if (miss1 || miss2) begin
        s1_d = miss2 ? sat_inc(s1_q) : s1_q;
        s2_d = miss1 ? sat_inc(s2_q) : s2_q;
        if (miss1 ^ miss2) dir_d = miss2;
        p1    = s1_d >= WIN;
        p2    = s2_d >= WIN;
        win_d = (p1 && p2) ? WIN_DRAW : p2 ? WIN_P2 : p1 ? WIN_P1 : WIN_NONE;
        st_d  = (p1 || p2) ? OVER : NEW_BALL;
      end
      OVER: if (press) begin
        st_d  = NEW_GAME;
        s1_d  = '0;
        s2_d  = '0;
        win_d = WIN_NONE;
      end
      default: st_d = NEW_GAME;
    endcase
    br_d = st_d != PLAY;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      st_q    <= NEW_GAME;
      start_q <= 1'b1;
      srv_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= WIN_NONE;
      dir_q   <= 1'b1;
      br_q    <= 1'b1;
    end else begin
      st_q    <= st_d;
      start_q <= start;
      srv_q   <= srv_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      br_q    <= br_d;
    end
  // Divider is held clear outside PLAY and on the cycles entering or leaving it
  move_tick_gen u_move (
    .clk        (clk),
    .rst        (rst),
    .clr        (st_q != PLAY || st_d != PLAY),
    .frame_tick (frame_tick),
    .div        (calc_div(BASE, sec1)),
    .move_en    (move_en)
  );
  assign state      = st_q;
  assign ball_reset = br_q;
  assign serve_dir  = dir_q;
  assign score1     = s1_q;
  assign score2     = s2_q;
  assign winner     = win_q;
endmodule
